victim_buffer_assoc: RTL

Parametrised, fully-associative victim buffer between the L1 cache and L2. It holds ENTRIES evicted L1 lines with per-entry dirty state and true-LRU replacement. L1 misses are serviced by swap on a hit and by an L2 fill on a miss. Dirty lines displaced from the buffer are written back to L2 through a request/response handshake.

---
 rtl/victim_buffer_assoc.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/victim_buffer_assoc.sv
// Fully-associative victim buffer between L1 and L2 with true-LRU replacement.
// Read hits are swapped out to L1, misses are filled from L2, dirty victims are written back.
module victim_buffer_assoc #(
  parameter  int ENTRIES = 4,
  parameter  int LINE_W  = 128,
  parameter  int TAG_W   = 12,
  parameter  int OFF_W   = 4,
  localparam int ADDR_W  = TAG_W + OFF_W,
  localparam int AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              l1_read,
  input  logic              l1_write,
  input  logic [TAG_W-1:0]  l1_rtag,
  input  logic [TAG_W-1:0]  l1_wtag,
  input  logic [LINE_W-1:0] l1_wdata,
  input  logic              l1_dirty_in,
  output logic              l1_resp,
  output logic              l1_hit,
  output logic [LINE_W-1:0] l1_rdata,
  output logic              l1_dirty_out,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_FETCH, S_EVICT, S_INSERT, S_RESP
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic              r_valid [ENTRIES];
  logic              r_dirty [ENTRIES];
  logic [AW-1:0]     r_age   [ENTRIES];
  logic [TAG_W-1:0]  r_tag   [ENTRIES];
  logic [LINE_W-1:0] r_line  [ENTRIES];

  logic              r_rd;
  logic              r_wr;
  logic [TAG_W-1:0]  r_rtag;
  logic [TAG_W-1:0]  r_wtag;
  logic [LINE_W-1:0] r_wdata;
  logic              r_wdirty;
  logic [AW-1:0]     r_tgt;

  logic              r_l1_hit;
  logic [LINE_W-1:0] r_l1_rdata;
  logic              r_l1_dirty_out;
  logic              r_l2_read;
  logic              r_l2_write;
  logic [ADDR_W-1:0] r_l2_address;
  logic [LINE_W-1:0] r_l2_wdata;

  logic [ENTRIES-1:0] w_rmatch;
  logic [ENTRIES-1:0] w_wmatch;
  logic [ENTRIES-1:0] w_invalid;
  logic [ENTRIES-1:0] w_lru;
  logic               w_rhit;
  logic               w_whit;
  logic [AW-1:0]      w_ridx;
  logic [AW-1:0]      w_widx;
  logic [AW-1:0]      w_tsel;
  logic               w_tgt_dirty;

  logic               w_ent_wr;
  logic [AW-1:0]      w_ent_idx;
  logic               w_ent_dirty;
  logic               w_inval;
  logic [AW-1:0]      w_inval_idx;
  logic               w_touch;
  logic [AW-1:0]      w_touch_idx;

  // Lowest set bit wins.
  function automatic logic [AW-1:0] f_enc(input logic [ENTRIES-1:0] v);
    f_enc = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (v[i]) f_enc = AW'(i);
    end
  endfunction

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_match
      assign w_rmatch[gi]  = r_valid[gi] && (r_tag[gi] == r_rtag);
      assign w_wmatch[gi]  = r_valid[gi] && (r_tag[gi] == r_wtag);
      assign w_invalid[gi] = !r_valid[gi];
      assign w_lru[gi]     = (r_age[gi] == AW'(ENTRIES - 1));
    end
  endgenerate

  assign w_rhit      = |w_rmatch;
  assign w_whit      = |w_wmatch;
  assign w_ridx      = f_enc(w_rmatch);
  assign w_widx      = f_enc(w_wmatch);
  assign w_tsel      = (|w_invalid) ? f_enc(w_invalid) : f_enc(w_lru);
  assign w_tgt_dirty = r_valid[w_tsel] && r_dirty[w_tsel];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (l1_read || l1_write) w_state_next = S_CHECK;
      S_CHECK: begin
        if (r_rd) w_state_next = w_rhit ? S_RESP : S_FETCH;
        else      w_state_next = S_INSERT;
      end
      S_FETCH:  if (l2_resp) w_state_next = r_wr ? S_INSERT : S_RESP;
      S_INSERT: w_state_next = (!w_whit && w_tgt_dirty) ? S_EVICT : S_RESP;
      S_EVICT:  if (l2_resp) w_state_next = S_RESP;
      S_RESP:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    l1_resp      = (r_state == S_RESP);
    l1_hit       = r_l1_hit;
    l1_rdata     = r_l1_rdata;
    l1_dirty_out = r_l1_dirty_out;
    l2_read      = r_l2_read;
    l2_write     = r_l2_write;
    l2_address   = r_l2_address;
    l2_wdata     = r_l2_wdata;
  end

  // Entry update strobes: one insert/overwrite, one invalidate and one LRU touch per cycle.
  always_comb begin
    w_ent_wr    = 1'b0;
    w_ent_idx   = '0;
    w_ent_dirty = 1'b0;
    w_inval     = 1'b0;
    w_inval_idx = '0;
    w_touch     = 1'b0;
    w_touch_idx = '0;
    case (r_state)
      S_CHECK: begin
        if (r_rd && w_rhit) begin
          if (r_wr) begin
            w_ent_wr    = 1'b1;
            w_ent_idx   = w_ridx;
            w_ent_dirty = r_wdirty;
            w_touch     = 1'b1;
            w_touch_idx = w_ridx;
          end else begin
            w_inval     = 1'b1;
            w_inval_idx = w_ridx;
          end
        end
      end
      S_INSERT: begin
        if (w_whit) begin
          w_ent_wr    = 1'b1;
          w_ent_idx   = w_widx;
          w_ent_dirty = r_dirty[w_widx] | r_wdirty;
          w_touch     = 1'b1;
          w_touch_idx = w_widx;
        end else if (!w_tgt_dirty) begin
          w_ent_wr    = 1'b1;
          w_ent_idx   = w_tsel;
          w_ent_dirty = r_wdirty;
          w_touch     = 1'b1;
          w_touch_idx = w_tsel;
        end
      end
      S_EVICT: begin
        if (l2_resp) begin
          w_ent_wr    = 1'b1;
          w_ent_idx   = r_tgt;
          w_ent_dirty = r_wdirty;
          w_touch     = 1'b1;
          w_touch_idx = r_tgt;
        end
      end
      default: ;
    endcase
  end

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid[gi] <= 1'b0;
          r_dirty[gi] <= 1'b0;
          r_age[gi]   <= AW'(gi);
        end else begin
          if (w_ent_wr && (w_ent_idx == AW'(gi))) begin
            r_valid[gi] <= 1'b1;
            r_dirty[gi] <= w_ent_dirty;
          end else if (w_inval && (w_inval_idx == AW'(gi))) begin
            r_valid[gi] <= 1'b0;
          end
          // Ages stay a permutation: only entries younger than the touched one shift.
          if (w_touch) begin
            if (w_touch_idx == AW'(gi))
              r_age[gi] <= '0;
            else if (r_age[gi] < r_age[w_touch_idx])
              r_age[gi] <= r_age[gi] + 1'b1;
          end
        end
      end
    end
  endgenerate

  // Tag and line storage is qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_ent_wr) begin
      r_tag[w_ent_idx]  <= r_wtag;
      r_line[w_ent_idx] <= r_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd           <= 1'b0;
      r_wr           <= 1'b0;
      r_rtag         <= '0;
      r_wtag         <= '0;
      r_wdata        <= '0;
      r_wdirty       <= 1'b0;
      r_tgt          <= '0;
      r_l1_hit       <= 1'b0;
      r_l1_rdata     <= '0;
      r_l1_dirty_out <= 1'b0;
      r_l2_read      <= 1'b0;
      r_l2_write     <= 1'b0;
      r_l2_address   <= '0;
      r_l2_wdata     <= '0;
    end else begin
      r_l2_read  <= (w_state_next == S_FETCH);
      r_l2_write <= (w_state_next == S_EVICT);
      case (r_state)
        S_IDLE: begin
          if (l1_read || l1_write) begin
            r_rd     <= l1_read;
            r_wr     <= l1_write;
            r_rtag   <= l1_rtag;
            r_wtag   <= l1_wtag;
            r_wdata  <= l1_wdata;
            r_wdirty <= l1_dirty_in;
          end
        end
        S_CHECK: begin
          if (r_rd && w_rhit) begin
            r_l1_hit       <= 1'b1;
            r_l1_rdata     <= r_line[w_ridx];
            r_l1_dirty_out <= r_dirty[w_ridx];
          end else begin
            r_l1_hit <= 1'b0;
            if (r_rd) r_l2_address <= {r_rtag, {OFF_W{1'b0}}};
          end
        end
        S_FETCH: begin
          if (l2_resp) begin
            r_l1_hit       <= 1'b0;
            r_l1_rdata     <= l2_rdata;
            r_l1_dirty_out <= 1'b0;
          end
        end
        S_INSERT: begin
          r_tgt <= w_tsel;
          if (!w_whit && w_tgt_dirty) begin
            r_l2_address <= {r_tag[w_tsel], {OFF_W{1'b0}}};
            r_l2_wdata   <= r_line[w_tsel];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
